axi_ram_slave: RTL
==================

// Module: axi_ram_slave
// PURPOSE
//   AXI3 responder (slave) backed by an on-chip word RAM; the far end of sram2axi_bridge.
//   Accepts AR/AW/W and returns R/B with programmable read latency.
//   Serves as the memory model in CPU-level simulation and as a small on-chip RAM.
//   One outstanding read and one outstanding write at a time; read and write paths run concurrently.
// PARAMETERS
//   ADDR_W    10  word-address bits; RAM holds 2**ADDR_W 32-bit words
//   RD_DELAY  1   cycles from AR handshake to first rvalid (0..15; 0 = next cycle)
// PORTS
//   clk      in   1   clock, all logic on posedge
//   reset    in   1   synchronous, active-high
//   arid     in   4   read ID, echoed on rid
//   araddr   in   32  read byte address; bits[1:0] ignored
//   arlen    in   8   beats-1; only [3:0] used (max 16 beats)
//   arsize   in   3   ignored; every beat is 4 bytes
//   arburst  in   2   00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
//   arlock/arcache/arprot  in  2/4/3  ignored
//   arvalid  in 1 / arready out 1   AR handshake
//   rid out 4 / rdata out 32 / rresp out 2 / rlast out 1   R payload
//   rvalid   out 1 / rready in 1    R handshake
//   awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2   as AR counterparts
//   awlock/awcache/awprot  in  2/4/3  ignored
//   awvalid  in 1 / awready out 1   AW handshake
//   wid in 4 (ignored) / wdata in 32 / wstrb in 4 / wlast in 1   W payload
//   wvalid   in 1 / wready out 1    W handshake
//   bid out 4 / bresp out 2         B payload
//   bvalid   out 1 / bready in 1    B handshake
// BEHAVIOUR
//   Reset: every output 0 while reset is high; arready=awready=1 on the first cycle after release. RAM contents are not cleared.
//   Read FSM (R_IDLE, R_WAIT, R_DATA):
//     R_IDLE: arready=1. On arvalid, latch id/addr/len/burst. Go to R_WAIT (or R_DATA if RD_DELAY=0).
//     R_WAIT: counter runs RD_DELAY-1..0; on 0, load rdata from mem[addr] and go to R_DATA.
//     R_DATA: rvalid=1; rlast=(beat==len). rdata/rid/rresp/rlast are registered and held while rvalid&&!rready.
//       On rready: beat+1; addr+4 for INCR, addr held for FIXED; load the next beat. After the last beat, return to R_IDLE with arready=1 on the next cycle.
//   Write FSM (W_IDLE, W_DATA, W_RESP):
//     W_IDLE: awready=1. On awvalid, latch fields and go to W_DATA.
//     W_DATA: wready=1. Each wvalid beat writes the bytes enabled by wstrb[i] into mem[addr][8i+7:8i]; addr advances as for read.
//       The burst ends on beat==len. Go to W_RESP.
//     W_RESP: bvalid=1, bid=latched awid. On bready, return to W_IDLE.
//   Response codes: OKAY=2'b00, SLVERR=2'b10.
//     A beat whose addr[31:ADDR_W+2]!=0 is out of range: the write is dropped; the read returns rdata=0 and rresp=SLVERR.
//     Any out-of-range write beat makes bresp=SLVERR.
//     wlast mismatch (wlast asserted before beat len, or absent at beat len) also makes bresp=SLVERR; the burst length still follows awlen.
//   Address arithmetic: 32-bit wrap on increment; the word index is addr[ADDR_W+1:2].
//   Same-cycle read and write to one word: the read load sees old data; the write is visible to later loads.
//   AR and AW may handshake in the same cycle; the two paths are fully independent.
//   Reset mid-burst: both FSMs return to IDLE with no response issued; beats already written stay in RAM.
//   Latency, single beat: AR handshake at cycle t -> rvalid at t+1+RD_DELAY. Last W beat at t -> bvalid at t+1.
// STRUCTURE
//   Shared include axi_defs.vh: burst encodings (FIXED/INCR/WRAP) and resp codes (OKAY/EXOKAY/SLVERR/DECERR).
//     The same include is used by sram2axi_bridge.
//   Sub-module axi_ram_mem: 2**ADDR_W x 32 array; one synchronous byte-enable write port; one read port sampled into the rdata register.
// TESTING
//   1. Reset held 3 cycles, released -> all outputs 0 during reset; arready=awready=1 next cycle.
//   2. AW addr 0x10, len 0, W 0xDEADBEEF strb 4'hF, then AR 0x10 id 3 -> bvalid OKAY; RD_DELAY=1 gives rvalid 2 cycles after AR; rdata 0xDEADBEEF, rid 3, rlast=1.
//   3. INCR write len 3 at 0x40 (data 1,2,3,4), read back len 3 with rready toggled 1-0-1-0 -> beats 1,2,3,4; data held during stall; rlast only on beat 4.
//   4. Write 0x11223344 to 0x20, then strb 4'b0101 data 0xAABBCCDD -> read 0x11BB33DD.
//   5. AR to 0x0001_0000 with ADDR_W=10 -> rresp=2'b10, rdata=0; write to the same address -> bresp=2'b10, RAM unchanged.
//   6. Reset asserted mid 4-beat read after beat 2 -> rvalid=0 next cycle; a new AR is accepted after release.

Source files
------------

// File: rtl/axi_ram_slave_pkg.sv
// Shared encodings, FSM state types and address helpers for the AXI3 RAM responder.
// WRAP bursts need no constant of their own: anything other than FIXED advances like INCR.
package axi_ram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd4;
    endfunction

    // True when the byte address lies above the 2**addr_w word window.
    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Word RAM with one synchronous byte-enable write port and one asynchronous read port.
// The read port feeds the responder's rdata register, so a same-cycle write is not visible to that load.
module axi_ram_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 responder over an on-chip word RAM: one outstanding read and one outstanding write,
// independent read/write FSMs, programmable first-beat read latency.
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_WAIT | latency down-counter running, first beat loads on terminal count
//   R_DATA | rvalid high, registered beat held until rready
//   W_IDLE | awready high, waiting for an AW handshake
//   W_DATA | wready high, writing one beat per wvalid
//   W_RESP | bvalid high until bready
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int RD_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [3:0] RD_CNT_INIT = 4'((RD_DELAY > 0) ? RD_DELAY - 1 : 0);

    r_state_t    r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d, r_len_q, r_len_d, r_beat_q, r_beat_d, r_cnt_q, r_cnt_d;
    logic [31:0] r_addr_q, r_addr_d, rdata_q, rdata_d;
    logic [1:0]  r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic        rlast_q, rlast_d, r_load;
    logic [31:0] rd_addr, mem_rdata;

    w_state_t    w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d, w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic        w_err_q, w_err_d, w_oor, mem_we;

    logic unused_ok;
    assign unused_ok = ^{arlen[7:4], arsize, arlock, arcache, arprot,
                         awlen[7:4], awsize, awlock, awcache, awprot, wid};

    axi_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_addr_q[ADDR_W+1:2]),
        .wstrb (wstrb),
        .wdata (wdata),
        .raddr (rd_addr[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_addr   = r_addr_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                rd_addr = araddr;
                if (arvalid) begin
                    r_id_d    = arid;
                    r_addr_d  = araddr;
                    r_len_d   = arlen[3:0];
                    r_burst_d = arburst;
                    r_beat_d  = 4'd0;
                    if (RD_DELAY == 0) begin
                        r_load    = 1'b1;
                        r_state_d = R_DATA;
                    end else begin
                        r_cnt_d   = RD_CNT_INIT;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    r_load    = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rd_addr  = next_addr(r_addr_q, r_burst_q);
                        r_addr_d = rd_addr;
                        r_beat_d = r_beat_q + 4'd1;
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load) begin
            rdata_d = addr_oor(rd_addr, ADDR_W) ? 32'd0 : mem_rdata;
            rresp_d = addr_oor(rd_addr, ADDR_W) ? RESP_SLVERR : RESP_OKAY;
            rlast_d = (r_beat_d == r_len_d);
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        w_oor     = addr_oor(w_addr_q, ADDR_W);
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_id_d    = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen[3:0];
                    w_burst_d = awburst;
                    w_beat_d  = 4'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we  = !w_oor && !reset;
                    // A misplaced or missing wlast is flagged, but awlen still sets the burst length.
                    w_err_d = w_err_q || w_oor || (wlast != (w_beat_q == w_len_q));
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 4'd1;
                        w_addr_d = next_addr(w_addr_q, w_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    // Outputs are forced low for as long as reset is high, including its first cycle.
    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = '0;
        if (!reset) begin
            arready = (r_state_q == R_IDLE);
            rvalid  = (r_state_q == R_DATA);
            rid     = r_id_q;
            rdata   = rdata_q;
            rresp   = rresp_q;
            rlast   = rlast_q;
            awready = (w_state_q == W_IDLE);
            wready  = (w_state_q == W_DATA);
            bvalid  = (w_state_q == W_RESP);
            bid     = w_id_q;
            bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule
